// File: rtl/flash_cache_pkg.sv
// ----------------------------------------------------------------------------
// flash_cache_pkg
// Shared definitions for the SPI flash read cache:
//   - state_e      : miss-handling FSM encodings (IDLE / REQ / WAIT)
//   - DEF_ADDR_W   : default word-address width (mem_address[21:2])
//   - DEF_LINES    : default number of direct-mapped lines
//   - CNT_W        : width of the optional hit/miss statistics counters
//   - sat_inc()    : saturating increment used by the statistics counters
// ----------------------------------------------------------------------------
package flash_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_LINES  = 16;
    localparam int CNT_W      = 16;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/flash_cache_store.sv
// ----------------------------------------------------------------------------
// flash_cache_store
// Line storage for the direct-mapped flash read cache: LINES entries of
// {tag, 32-bit data} plus a valid vector. One synchronous write port,
// combinational read port, and a synchronous clear of all valid bits.
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset (all lines invalid)
//   clear_all    invalidate every line at the next edge (wins over a write)
//   wr_en        write tag/data at wr_idx
//   wr_valid     valid bit value stored with the write
//   wr_idx       line index to write
//   wr_tag       tag to store
//   wr_data      data word to store
//   rd_idx       line index to read (combinational)
//   rd_valid     valid bit of line rd_idx
//   rd_tag       stored tag of line rd_idx
//   rd_data      stored data of line rd_idx
// ----------------------------------------------------------------------------
import flash_cache_pkg::*;

module flash_cache_store #(
    parameter int LINES = DEF_LINES,
    parameter int TAG_W = DEF_ADDR_W - $clog2(DEF_LINES),
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_all,
    input  logic             wr_en,
    input  logic             wr_valid,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      data_d [LINES];

    // Clear-all is applied after the write so a fill landing in the same
    // cycle as a flush leaves the line invalid.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
            valid_d[wr_idx] = wr_valid;
        end
        if (clear_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/spi_flash_read_cache.sv
// ----------------------------------------------------------------------------
// spi_flash_read_cache
// Direct-mapped, one-word-per-line read cache between the FemtoRV32 bus and
// MappedSPIFlash. Hits return data one cycle after rstrb without raising
// rbusy; misses issue one flash request, wait for the flash busy pulse to
// complete, refill the line and return the word.
//
// Configuration macro: FLASH_CACHE_STATS_EN adds saturating hit/miss counters
// (hit_count / miss_count ports). Without it those ports do not exist.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   word_address        CPU word address, sampled with rstrb
//   rstrb               CPU read strobe (one-cycle pulse)
//   rdata               returned read data (registered)
//   rbusy               high while a miss is outstanding (registered)
//   flush               one-cycle pulse invalidating all lines
//   flash_word_address  address presented to MappedSPIFlash
//   flash_rstrb         one-cycle request pulse to MappedSPIFlash
//   flash_rdata         word returned by MappedSPIFlash
//   flash_rbusy         MappedSPIFlash busy
//   hit_count           [FLASH_CACHE_STATS_EN] saturating hit counter
//   miss_count          [FLASH_CACHE_STATS_EN] saturating miss counter
// ----------------------------------------------------------------------------
import flash_cache_pkg::*;

module spi_flash_read_cache #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINES  = DEF_LINES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] word_address,
    input  logic              rstrb,
    output logic [31:0]       rdata,
    output logic              rbusy,
    input  logic              flush,
    output logic [ADDR_W-1:0] flash_word_address,
    output logic              flash_rstrb,
    input  logic [31:0]       flash_rdata,
    input  logic              flash_rbusy
`ifdef FLASH_CACHE_STATS_EN
    ,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    state_e            state_q, state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rbusy_q, rbusy_d;
    logic              flash_rstrb_q, flash_rstrb_d;
    logic [ADDR_W-1:0] flash_word_address_q, flash_word_address_d;
    logic              seen_busy_q, seen_busy_d;
    logic              poisoned_q, poisoned_d;

    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;
    logic              hit;
    logic              fill_done;
    logic              fill_valid;

    assign lookup_idx = word_address[IDX_W-1:0];
    assign lookup_tag = word_address[ADDR_W-1:IDX_W];

    // A flush in the same cycle as the lookup forces a miss.
    assign hit = rd_valid && (rd_tag == lookup_tag) && !flush;

    // The fetch finishes on the falling edge of flash_rbusy, but only after
    // busy has actually been seen high (it may still be low on the first
    // WAIT cycle).
    assign fill_done = (state_q == WAIT) && seen_busy_q && !flash_rbusy;

    // A flush that arrived while the fetch was in flight means the returned
    // word may be stale relative to the flush, so the line stays invalid.
    assign fill_valid = !poisoned_q && !flush;

    // The latched miss address doubles as the flash address register.
    flash_cache_store #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_all (flush),
        .wr_en     (fill_done),
        .wr_valid  (fill_valid),
        .wr_idx    (flash_word_address_q[IDX_W-1:0]),
        .wr_tag    (flash_word_address_q[ADDR_W-1:IDX_W]),
        .wr_data   (flash_rdata),
        .rd_idx    (lookup_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data)
    );

    // Next-state logic for the miss FSM; all outputs are registered so the
    // request pulse coincides with the REQ state and rbusy rises the cycle
    // after rstrb. rstrb outside IDLE is ignored.
    always_comb begin
        state_d              = state_q;
        rdata_d              = rdata_q;
        rbusy_d              = rbusy_q;
        flash_rstrb_d        = 1'b0;
        flash_word_address_d = flash_word_address_q;
        seen_busy_d          = seen_busy_q;
        poisoned_d           = poisoned_q;
        case (state_q)
            IDLE: begin
                if (rstrb) begin
                    if (hit) begin
                        rdata_d = rd_data;
                    end else begin
                        flash_word_address_d = word_address;
                        flash_rstrb_d        = 1'b1;
                        rbusy_d              = 1'b1;
                        poisoned_d           = 1'b0;
                        state_d              = REQ;
                    end
                end
            end
            REQ: begin
                seen_busy_d = 1'b0;
                if (flush) begin
                    poisoned_d = 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                if (flash_rbusy) begin
                    seen_busy_d = 1'b1;
                end
                if (flush) begin
                    poisoned_d = 1'b1;
                end
                if (fill_done) begin
                    rdata_d = flash_rdata;
                    rbusy_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= IDLE;
            rdata_q              <= '0;
            rbusy_q              <= 1'b0;
            flash_rstrb_q        <= 1'b0;
            flash_word_address_q <= '0;
            seen_busy_q          <= 1'b0;
            poisoned_q           <= 1'b0;
        end else begin
            state_q              <= state_d;
            rdata_q              <= rdata_d;
            rbusy_q              <= rbusy_d;
            flash_rstrb_q        <= flash_rstrb_d;
            flash_word_address_q <= flash_word_address_d;
            seen_busy_q          <= seen_busy_d;
            poisoned_q           <= poisoned_d;
        end
    end

    assign rdata              = rdata_q;
    assign rbusy              = rbusy_q;
    assign flash_rstrb        = flash_rstrb_q;
    assign flash_word_address = flash_word_address_q;

`ifdef FLASH_CACHE_STATS_EN
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    // Only lookups accepted in IDLE are counted; flush clears both counters
    // even if a lookup arrives in the same cycle.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (flush) begin
            hit_count_d  = '0;
            miss_count_d = '0;
        end else if ((state_q == IDLE) && rstrb) begin
            if (hit) begin
                hit_count_d = sat_inc(hit_count_q);
            end else begin
                miss_count_d = sat_inc(miss_count_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_spi_flash_read_cache.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_read_cache
// Self-checking bench for spi_flash_read_cache. A behavioural MappedSPIFlash
// model answers requests after a programmable number of busy cycles; the
// expected read data is pushed to a scoreboard queue when a read is issued
// and popped when the cache returns the word. Define FLASH_CACHE_STATS_EN to
// also exercise the hit/miss counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_flash_read_cache;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] word_address;
    logic              rstrb;
    logic [31:0]       rdata;
    logic              rbusy;
    logic              flush;
    logic [ADDR_W-1:0] flash_word_address;
    logic              flash_rstrb;
    logic [31:0]       flash_rdata;
    logic              flash_rbusy;
`ifdef FLASH_CACHE_STATS_EN
    logic [15:0]       hit_count;
    logic [15:0]       miss_count;
`endif

    int checks = 0;
    int passed = 0;

    // Flash model state
    int                flashLat = 40;
    int                flashCnt;
    int                flashReqCount = 0;
    logic [ADDR_W-1:0] flashReqAddr;

    logic [31:0] expQ[$];

    spi_flash_read_cache #(.ADDR_W(ADDR_W), .LINES(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .word_address       (word_address),
        .rstrb              (rstrb),
        .rdata              (rdata),
        .rbusy              (rbusy),
        .flush              (flush),
        .flash_word_address (flash_word_address),
        .flash_rstrb        (flash_rstrb),
        .flash_rdata        (flash_rdata),
        .flash_rbusy        (flash_rbusy)
`ifdef FLASH_CACHE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Contents of the flash as seen by the bench.
    function automatic logic [31:0] flashWord(input logic [ADDR_W-1:0] a);
        if (a == 20'h00010) begin
            return 32'hDEADBEEF;
        end
        return {12'h5A3, a};
    endfunction

    // MappedSPIFlash stand-in: busy rises the cycle after the request and
    // stays high for flashLat cycles; data is presented when busy falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_rbusy <= 1'b0;
            flash_rdata <= 32'h0;
            flashCnt    <= 0;
        end else if (flash_rstrb) begin
            flash_rbusy  <= 1'b1;
            flashCnt     <= flashLat - 1;
            flashReqAddr <= flash_word_address;
        end else if (flash_rbusy) begin
            if (flashCnt == 0) begin
                flash_rbusy <= 1'b0;
                flash_rdata <= flashWord(flashReqAddr);
            end else begin
                flashCnt <= flashCnt - 1;
            end
        end
    end

    // Counts request pulses seen at active clock edges.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && flash_rstrb === 1'b1) begin
            flashReqCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic pulseFlush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Issue one read and follow it to completion. expLat > 0 also checks the
    // number of cycles rbusy stays high; flushAt > 0 injects a flush pulse
    // that many cycles into the miss.
    task automatic applyStimulus(input string tag, input logic [ADDR_W-1:0] addr,
                                 input bit expHit, input int expLat, input int flushAt);
        int          hi;
        int          reqBefore;
        logic [31:0] exp;
        reqBefore = flashReqCount;
        @(negedge clk);
        word_address = addr;
        rstrb        = 1'b1;
        expQ.push_back(flashWord(addr));
        @(posedge clk);
        #1;
        rstrb = 1'b0;
        checkOutput({tag, "_rbusy_after_rstrb"}, {31'b0, rbusy}, {31'b0, !expHit});
        hi = 0;
        while (rbusy === 1'b1 && hi < 1000) begin
            hi++;
            flush = (hi == flushAt);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        checkOutput({tag, "_done_in_time"}, {31'b0, rbusy}, 32'd0);
        if (expLat > 0) begin
            checkOutput({tag, "_busy_cycles"}, 32'(hi), 32'(expLat));
        end
        exp = expQ.pop_front();
        checkOutput({tag, "_rdata"}, rdata, exp);
        checkOutput({tag, "_flash_reqs"}, 32'(flashReqCount - reqBefore), expHit ? 32'd0 : 32'd1);
        if (!expHit) begin
            checkOutput({tag, "_flash_addr"}, {12'b0, flashReqAddr}, {12'b0, addr});
        end
    endtask

    initial begin
        int reqBefore;
        rst_n        = 1'b0;
        word_address = '0;
        rstrb        = 1'b0;
        flush        = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_rbusy", {31'b0, rbusy}, 32'd0);
        checkOutput("reset_flash_rstrb", {31'b0, flash_rstrb}, 32'd0);
        checkOutput("reset_flash_addr", {12'b0, flash_word_address}, 32'd0);
`ifdef FLASH_CACHE_STATS_EN
        checkOutput("reset_hit_count", {16'b0, hit_count}, 32'd0);
        checkOutput("reset_miss_count", {16'b0, miss_count}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss: 40-cycle flash fetch gives 42 busy cycles
        pulseFlush();
        flashLat = 40;
        applyStimulus("cold_miss", 20'h00010, 1'b0, 42, 0);

        // Hit on the same address
        applyStimulus("hit", 20'h00010, 1'b1, 0, 0);

        // Conflict on index 0
        flashLat = 5;
        applyStimulus("conflict_a", 20'h00020, 1'b0, 7, 0);
        applyStimulus("conflict_b", 20'h00010, 1'b0, 7, 0);
        applyStimulus("conflict_hit", 20'h00010, 1'b1, 0, 0);

        // Other indices and address extremes
        applyStimulus("idx5_miss", 20'h00035, 1'b0, 7, 0);
        applyStimulus("idx5_hit", 20'h00035, 1'b1, 0, 0);
        applyStimulus("max_miss", 20'hFFFFF, 1'b0, 7, 0);
        applyStimulus("max_hit", 20'hFFFFF, 1'b1, 0, 0);
        applyStimulus("zero_miss", 20'h00000, 1'b0, 7, 0);
        applyStimulus("zero_hit", 20'h00000, 1'b1, 0, 0);
        applyStimulus("idx5_still_hit", 20'h00035, 1'b1, 0, 0);

        // Flush during WAIT: data still returned but line left invalid
        flashLat = 8;
        applyStimulus("flush_mid_miss", 20'h00030, 1'b0, 10, 5);
        applyStimulus("flush_reread", 20'h00030, 1'b0, 10, 0);
        applyStimulus("flush_reread_hit", 20'h00030, 1'b1, 0, 0);

        // Reset in the middle of a miss
        reqBefore = flashReqCount;
        @(negedge clk);
        word_address = 20'h00041;
        rstrb        = 1'b1;
        @(posedge clk);
        #1;
        rstrb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_mid_busy_before", {31'b0, rbusy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_rbusy", {31'b0, rbusy}, 32'd0);
        checkOutput("rst_mid_flash_rstrb", {31'b0, flash_rstrb}, 32'd0);
        checkOutput("rst_mid_reqs", 32'(flashReqCount - reqBefore), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("rst_prior_hit_misses", 20'h00030, 1'b0, 10, 0);

`ifdef FLASH_CACHE_STATS_EN
        // Statistics: 3 misses then 5 hits, then flush clears both
        flashLat = 3;
        pulseFlush();
        checkOutput("stats_flush_hits", {16'b0, hit_count}, 32'd0);
        checkOutput("stats_flush_misses", {16'b0, miss_count}, 32'd0);
        applyStimulus("st_m1", 20'h00001, 1'b0, 5, 0);
        applyStimulus("st_m2", 20'h00002, 1'b0, 5, 0);
        applyStimulus("st_m3", 20'h00003, 1'b0, 5, 0);
        applyStimulus("st_h1", 20'h00001, 1'b1, 0, 0);
        applyStimulus("st_h2", 20'h00002, 1'b1, 0, 0);
        applyStimulus("st_h3", 20'h00003, 1'b1, 0, 0);
        applyStimulus("st_h4", 20'h00001, 1'b1, 0, 0);
        applyStimulus("st_h5", 20'h00002, 1'b1, 0, 0);
        checkOutput("stats_miss_count", {16'b0, miss_count}, 32'd3);
        checkOutput("stats_hit_count", {16'b0, hit_count}, 32'd5);
        pulseFlush();
        checkOutput("stats_cleared_hits", {16'b0, hit_count}, 32'd0);
        checkOutput("stats_cleared_misses", {16'b0, miss_count}, 32'd0);
`endif

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
